// File: rtl/dlx_icache_dm_pkg.sv
// Shared state type and default geometry for the direct-mapped DLX instruction cache.
package dlx_icache_dm_pkg;

   localparam int unsigned ICACHE_ADDR_W  = 16;
   localparam int unsigned ICACHE_LINE_W  = 128;
   localparam int unsigned ICACHE_INDEX_W = 5;
   localparam int unsigned ICACHE_TAG_W   = 7;
   localparam int unsigned ICACHE_MEM_W   = 32;
   localparam int unsigned ICACHE_CNT_W   = 16;

   typedef enum logic [1:0] {IC_IDLE, IC_REFILL, IC_WRITE} icache_state;

endpackage

// File: rtl/dlx_icache_dm_if.sv
// Request/return bus: master drives req/addr, slave returns rdata with a ready/valid strobe.
interface dlx_icache_dm_if
   import dlx_icache_dm_pkg::*;
#(
   parameter int unsigned ADDR_W = ICACHE_ADDR_W,
   parameter int unsigned DATA_W = 32
);
   logic              req;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] rdata;
   logic              ready;

   modport master (output req, addr, input rdata, ready);
   modport slave  (input req, addr, output rdata, ready);
endinterface

// File: rtl/dlx_icache_dm_refill_buf.sv
// Collects refill beats into a full cache line; last_beat flags the beat that completes it.
module dlx_icache_dm_refill_buf
   import dlx_icache_dm_pkg::*;
#(
   parameter int unsigned LINE_W = ICACHE_LINE_W,
   parameter int unsigned MEM_W  = ICACHE_MEM_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              beat_en,
   input  logic [MEM_W-1:0]  beat_data,
   output logic [LINE_W-1:0] line,
   output logic              last_beat
);
   localparam int unsigned BEATS = LINE_W / MEM_W;
   localparam int unsigned CBW   = (BEATS > 1) ? $clog2(BEATS) : 1;

   logic [CBW-1:0]    cnt_q, cnt_d;
   logic [LINE_W-1:0] line_q, line_d;

   always_comb begin
      cnt_d     = cnt_q;
      line_d    = line_q;
      last_beat = beat_en && (cnt_q == CBW'(BEATS - 1));
      if (beat_en) begin
         for (int unsigned b = 0; b < BEATS; b++) begin
            if (cnt_q == CBW'(b)) line_d[b*MEM_W +: MEM_W] = beat_data;
         end
         cnt_d = last_beat ? '0 : cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q  <= '0;
         line_q <= '0;
      end else begin
         cnt_q  <= cnt_d;
         line_q <= line_d;
      end
   end

   assign line = line_q;
endmodule

// File: rtl/dlx_icache_dm.sv
// Direct-mapped read-only instruction cache: same-cycle hits, line refill over the mem bus,
// single-cycle flush and saturating hit/miss counters.
module dlx_icache_dm
   import dlx_icache_dm_pkg::*;
#(
   parameter int unsigned ADDR_W  = ICACHE_ADDR_W,
   parameter int unsigned LINE_W  = ICACHE_LINE_W,
   parameter int unsigned INDEX_W = ICACHE_INDEX_W,
   parameter int unsigned MEM_W   = ICACHE_MEM_W,
   parameter int unsigned CNT_W   = ICACHE_CNT_W
) (
   input  logic              clk,
   input  logic              rst,
   dlx_icache_dm_if.slave    cpu,
   dlx_icache_dm_if.master   mem,
   input  logic              flush,
   output logic [CNT_W-1:0]  hit_cnt,
   output logic [CNT_W-1:0]  miss_cnt
);
   localparam int unsigned OFF_W  = $clog2(LINE_W / 8);
   localparam int unsigned TAG_W  = ADDR_W - INDEX_W - OFF_W;
   localparam int unsigned WORD_W = OFF_W - 2;
   localparam int unsigned LINES  = 2 ** INDEX_W;

   icache_state             state_q, state_d;
   logic [LINES-1:0]        valid_q, valid_d;
   logic [TAG_W-1:0]        tag_q  [LINES];
   logic [TAG_W-1:0]        tag_d  [LINES];
   logic [LINE_W-1:0]       data_q [LINES];
   logic [LINE_W-1:0]       data_d [LINES];
   logic                    flush_pend_q, flush_pend_d;
   logic                    replay_q, replay_d;
   logic [ADDR_W-1:0]       mem_addr_q, mem_addr_d;
   logic [CNT_W-1:0]        hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

   logic [INDEX_W-1:0]      idx, ridx;
   logic [TAG_W-1:0]        tag, rtag;
   logic [WORD_W-1:0]       word;
   logic [LINE_W-1:0]       cur_line, refill_line;
   logic                    hit, last_beat, flush_now;

   assign idx      = cpu.addr[OFF_W +: INDEX_W];
   assign tag      = cpu.addr[ADDR_W-1 -: TAG_W];
   assign word     = cpu.addr[2 +: WORD_W];
   assign ridx     = mem_addr_q[OFF_W +: INDEX_W];
   assign rtag     = mem_addr_q[ADDR_W-1 -: TAG_W];
   assign cur_line = data_q[idx];
   assign hit      = cpu.req && (state_q == IC_IDLE) && valid_q[idx] && (tag_q[idx] == tag);

   assign cpu.ready = hit;
   assign cpu.rdata = hit ? cur_line[{word, 5'd0} +: 32] : '0;
   assign mem.req   = (state_q == IC_REFILL);
   assign mem.addr  = mem_addr_q;
   assign hit_cnt   = hit_cnt_q;
   assign miss_cnt  = miss_cnt_q;

   dlx_icache_dm_refill_buf #(.LINE_W(LINE_W), .MEM_W(MEM_W)) u_refill_buf (
      .clk       (clk),
      .rst       (rst),
      .beat_en   (mem.req && mem.ready),
      .beat_data (mem.rdata),
      .line      (refill_line),
      .last_beat (last_beat)
   );

   // The replay hit that closes a miss is not a second event: replay_q keeps it out of hit_cnt.
   always_comb begin
      state_d      = state_q;
      valid_d      = valid_q;
      tag_d        = tag_q;
      data_d       = data_q;
      flush_pend_d = flush_pend_q;
      replay_d     = 1'b0;
      mem_addr_d   = mem_addr_q;
      hit_cnt_d    = hit_cnt_q;
      miss_cnt_d   = miss_cnt_q;
      flush_now    = flush_pend_q || flush;
      unique case (state_q)
         IC_IDLE: begin
            if (flush) valid_d = '0;
            if (hit && !replay_q) hit_cnt_d = hit_cnt_q + CNT_W'(hit_cnt_q != '1);
            if (cpu.req && !hit) begin
               state_d    = IC_REFILL;
               mem_addr_d = {cpu.addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
               miss_cnt_d = miss_cnt_q + CNT_W'(miss_cnt_q != '1);
            end
         end
         IC_REFILL: begin
            if (flush) flush_pend_d = 1'b1;
            if (last_beat) state_d = IC_WRITE;
         end
         IC_WRITE: begin
            if (flush_now) valid_d = '0;
            valid_d[ridx] = !flush_now;
            tag_d[ridx]   = rtag;
            data_d[ridx]  = refill_line;
            flush_pend_d  = 1'b0;
            replay_d      = 1'b1;
            state_d       = IC_IDLE;
         end
         default: state_d = IC_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IC_IDLE;
         valid_q      <= '0;
         flush_pend_q <= 1'b0;
         replay_q     <= 1'b0;
         mem_addr_q   <= '0;
         hit_cnt_q    <= '0;
         miss_cnt_q   <= '0;
      end else begin
         state_q      <= state_d;
         valid_q      <= valid_d;
         flush_pend_q <= flush_pend_d;
         replay_q     <= replay_d;
         mem_addr_q   <= mem_addr_d;
         hit_cnt_q    <= hit_cnt_d;
         miss_cnt_q   <= miss_cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      tag_q  <= tag_d;
      data_q <= data_d;
   end
endmodule

// File: tb/tb_dlx_icache_dm.sv
// Bench for dlx_icache_dm: directed scenarios plus random fetches against a line-level cache model.
module tb_dlx_icache_dm;
   import dlx_icache_dm_pkg::*;

   localparam int unsigned AW = 16, LW = 128, IW = 5, MW = 32, CW = 16;
   localparam int unsigned BEATS = LW / MW;
   localparam int unsigned LAT0 = BEATS + 2;
   localparam int unsigned CMAX = 65535;

   logic clk = 1'b0;
   logic rst, flush;
   logic [CW-1:0] hit_cnt, miss_cnt;

   dlx_icache_dm_if #(.ADDR_W(AW), .DATA_W(32)) cpu ();
   dlx_icache_dm_if #(.ADDR_W(AW), .DATA_W(MW)) mem ();

   dlx_icache_dm #(.ADDR_W(AW), .LINE_W(LW), .INDEX_W(IW), .MEM_W(MW), .CNT_W(CW)) dut (
      .clk      (clk),
      .rst      (rst),
      .cpu      (cpu),
      .mem      (mem),
      .flush    (flush),
      .hit_cnt  (hit_cnt),
      .miss_cnt (miss_cnt)
   );

   always #5 clk = ~clk;

   logic [31:0] mem_words [0:16383];
   int unsigned gap_cfg = 0;
   int unsigned rsp_beat = 0, rsp_gap = 0;
   int unsigned total = 0, passes = 0;
   bit          mvalid [32];
   int unsigned mtag   [32];
   int unsigned exp_hits = 0, exp_misses = 0;

   // Memory responder: one beat per cycle, gap_cfg idle cycles between beats.
   initial begin
      mem.ready = 1'b0;
      mem.rdata = '0;
      forever begin
         @(negedge clk);
         if (mem.ready) begin
            rsp_beat++;
            rsp_gap = gap_cfg;
         end
         if (!mem.req || rst) begin
            rsp_beat  = 0;
            rsp_gap   = 0;
            mem.ready = 1'b0;
         end else if (rsp_gap > 0) begin
            rsp_gap--;
            mem.ready = 1'b0;
         end else begin
            mem.ready = 1'b1;
            mem.rdata = mem_words[int'(mem.addr[15:2]) + rsp_beat];
         end
      end
   end

   function automatic int unsigned sat(input int unsigned v);
      return (v > CMAX) ? CMAX : v;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic check_counters(input string tag);
      check({tag, "_hit_cnt"}, hit_cnt, exp_hits);
      check({tag, "_miss_cnt"}, miss_cnt, exp_misses);
   endtask

   task automatic model_clear();
      for (int i = 0; i < 32; i++) mvalid[i] = 1'b0;
   endtask

   // One fetch; flush_at < 0 means no flush, otherwise flush pulses in that cycle of the request.
   task automatic fetch(input string tag, input logic [15:0] a, input int unsigned gap,
                        input int flush_at);
      int unsigned idx, tg;
      bit hit, flushed;
      int lat, cyc;
      idx = a[8:4];
      tg  = a[15:9];
      gap_cfg = gap;
      hit = mvalid[idx] && (mtag[idx] == tg);
      lat = hit ? 0 : int'(LAT0 + gap * (BEATS - 1));
      flushed = (flush_at == 0) || (!hit && flush_at > 0 && flush_at < lat);
      if (!hit && flush_at > 0 && flush_at < lat) lat = lat * 2;
      @(negedge clk);
      cpu.req  = 1'b1;
      cpu.addr = a;
      cyc = 0;
      flush = (flush_at == 0);
      #1;
      forever begin
         if (cyc == 1 && !hit) begin
            check({tag, "_mem_req"}, mem.req, 1'b1);
            check({tag, "_mem_addr"}, mem.addr, {a[15:4], 4'h0});
         end
         if (cpu.ready || cyc >= lat + 40) break;
         @(negedge clk);
         cyc++;
         flush = (cyc == flush_at);
         #1;
      end
      check({tag, "_latency"}, cyc, lat);
      check({tag, "_rdata"}, cpu.rdata, mem_words[a[15:2]]);
      if (flushed) model_clear();
      if (hit) exp_hits = sat(exp_hits + 1);
      else begin
         exp_misses = sat(exp_misses + ((lat > int'(LAT0 + gap * (BEATS - 1))) ? 2 : 1));
         mvalid[idx] = 1'b1;
         mtag[idx]   = tg;
      end
      @(negedge clk);
      flush   = 1'b0;
      cpu.req = 1'b0;
      #1;
      check_counters(tag);
   endtask

   initial begin
      logic [15:0] ra;
      for (int i = 0; i < 16384; i++) mem_words[i] = $urandom;
      mem_words[16] = 32'h11111111;
      mem_words[17] = 32'h22222222;
      mem_words[18] = 32'h33333333;
      mem_words[19] = 32'h44444444;
      model_clear();

      rst = 1'b1; flush = 1'b0; cpu.req = 1'b0; cpu.addr = '0;
      repeat (3) @(negedge clk);
      #1;
      check("rst_ready", cpu.ready, 1'b0);
      check("rst_rdata", cpu.rdata, 32'h0);
      check("rst_mem_req", mem.req, 1'b0);
      check("rst_mem_addr", mem.addr, 16'h0);
      check_counters("rst");
      @(negedge clk);
      rst = 1'b0;

      fetch("first_miss", 16'h0040, 0, -1);
      fetch("same_line_hit", 16'h0048, 0, -1);
      fetch("conflict_a", 16'h0240, 0, -1);
      fetch("conflict_b", 16'h0040, 0, -1);
      fetch("flush_in_refill", 16'h0080, 0, 3);
      fetch("flush_after_hit", 16'h0084, 0, -1);
      fetch("gap3_miss", 16'h00C4, 3, -1);
      fetch("gap3_hit", 16'h00CC, 0, -1);
      fetch("flush_idle_hit", 16'h00C0, 0, 0);
      fetch("after_idle_flush", 16'h00C8, 0, -1);
      fetch("flush_with_miss", 16'h0300, 0, 0);
      fetch("flush_miss_kept", 16'h030C, 0, -1);

      // Reset while beat 1 is on the bus.
      @(negedge clk);
      gap_cfg  = 0;
      cpu.req  = 1'b1;
      cpu.addr = 16'h0100;
      repeat (2) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("rst_mid_mem_req", mem.req, 1'b0);
      check("rst_mid_ready", cpu.ready, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      cpu.req = 1'b0;
      model_clear();
      exp_hits = 0;
      exp_misses = 0;
      #1;
      check_counters("rst_mid");
      fetch("post_rst_miss", 16'h0040, 0, -1);

      for (int n = 0; n < 40; n++) begin
         ra = 16'((($urandom_range(0, 2)) << 9) | (($urandom_range(0, 3)) << 4)
                 | (($urandom_range(0, 3)) << 2));
         fetch("rand", ra, $urandom_range(0, 2), ($urandom_range(0, 7) == 0) ? 3 : -1);
      end

      fetch("sat_prime", 16'h0040, 0, -1);
      @(negedge clk);
      cpu.req  = 1'b1;
      cpu.addr = 16'h0040;
      repeat (65540) @(negedge clk);
      exp_hits = sat(exp_hits + 65540);
      #1;
      check("sat_ready", cpu.ready, 1'b1);
      check("sat_hit_cnt", hit_cnt, 16'hFFFF);
      check_counters("sat");
      cpu.req = 1'b0;
      fetch("sat_sticky", 16'h0044, 0, -1);

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end
endmodule
